// File: rtl/payment_collector.sv
// -----------------------------------------------------------------------------
// payment_collector
//
// Payment accumulator for the bar-code checkout path. A price loaded in IDLE
// opens a collection session. Bank notes of four configurable denominations
// are then accumulated as credit. A one-cycle vend pulse fires once the credit
// covers the price. Any remainder is paid out as change, and on cancel or
// timeout the credit is refunded. Payout uses a req/ack handshake with the
// change dispenser, one CHANGE_UNIT per acknowledge.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   price_valid_i  in   one-cycle strobe loading price_i (IDLE only)
//   price_i        in   product price, CREDIT_W bits
//   note_valid_i   in   one-cycle strobe: a note is presented
//   note_code_i    in   denomination select (0..3)
//   cancel_i       in   customer abort
//   change_ack_i   in   dispenser has paid one CHANGE_UNIT
//   credit_o       out  current credit (registered)
//   state_o        out  00 IDLE, 01 COLLECT, 10 CHANGE, 11 REFUND
//   note_accept_o  out  one-cycle pulse: note taken
//   note_reject_o  out  one-cycle pulse: note returned
//   vend_o         out  one-cycle pulse: product released
//   change_req_o   out  level: dispenser must pay one CHANGE_UNIT
// -----------------------------------------------------------------------------
module payment_collector #(
  parameter int CREDIT_W       = 8,
  parameter int DENOM0         = 10,
  parameter int DENOM1         = 20,
  parameter int DENOM2         = 50,
  parameter int DENOM3         = 0,
  parameter int MAX_CREDIT     = 200,
  parameter int CHANGE_UNIT    = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                price_valid_i,
  input  logic [CREDIT_W-1:0] price_i,
  input  logic                note_valid_i,
  input  logic [1:0]          note_code_i,
  input  logic                cancel_i,
  input  logic                change_ack_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [1:0]          state_o,
  output logic                note_accept_o,
  output logic                note_reject_o,
  output logic                vend_o,
  output logic                change_req_o
);

  // The timer only has to reach TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES)
  // bits are enough.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CREDIT_W-1:0] MAX_CR   = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   MAX_CR_W = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] UNIT_CR  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam int DENOM_TAB [4] = '{DENOM0, DENOM1, DENOM2, DENOM3};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_CHANGE  = 2'b10,
    S_REFUND  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                accept_q, accept_d;
  logic                reject_q, reject_d;
  logic                vend_q, vend_d;

  // Denomination values widened to CREDIT_W+1 bits so the credit + note sum
  // cannot wrap before it is compared against MAX_CREDIT.
  logic [CREDIT_W:0] denom_val [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_denom
      assign denom_val[gi] = (CREDIT_W+1)'(DENOM_TAB[gi]);
    end
  endgenerate

  logic [CREDIT_W:0] note_value;
  logic [CREDIT_W:0] note_sum;
  logic [CREDIT_W:0] remainder;
  logic              note_ok;
  logic              price_ok;
  logic              credit_ge_unit;
  logic              timeout_hit;
  logic              paying;

  assign note_value     = denom_val[note_code_i];
  assign note_sum       = {1'b0, credit_q} + note_value;
  assign remainder      = note_sum - {1'b0, price_q};
  // A zero-valued denomination marks a disabled note code.
  assign note_ok        = (note_value != '0) && (note_sum <= MAX_CR_W);
  assign price_ok       = (price_i != '0) && (price_i <= MAX_CR);
  assign credit_ge_unit = (credit_q >= UNIT_CR);
  assign timeout_hit    = TIMEOUT_EN && (timer_q == TIMER_LAST);
  assign paying         = (state_q == S_CHANGE) || (state_q == S_REFUND);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    timer_d  = timer_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    vend_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        credit_d = '0;
        reject_d = note_valid_i;
        if (price_valid_i && price_ok) begin
          price_d = price_i;
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (cancel_i) begin
          // Cancel takes priority over a note presented in the same cycle.
          reject_d = note_valid_i;
          state_d  = (credit_q != '0) ? S_REFUND : S_IDLE;
        end else if (note_valid_i && note_ok) begin
          accept_d = 1'b1;
          timer_d  = '0;
          if (note_sum < {1'b0, price_q}) begin
            credit_d = note_sum[CREDIT_W-1:0];
          end else begin
            vend_d   = 1'b1;
            credit_d = remainder[CREDIT_W-1:0];
            state_d  = (remainder != '0) ? S_CHANGE : S_IDLE;
          end
        end else begin
          // No accepted note this cycle: a presented note bounces and the
          // idle timer keeps running.
          reject_d = note_valid_i;
          if (timeout_hit) begin
            state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
          end else if (TIMEOUT_EN) begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      S_CHANGE, S_REFUND: begin
        reject_d = note_valid_i;
        if (!credit_ge_unit) begin
          // Residual below one unit cannot be dispensed and is dropped.
          credit_d = '0;
          state_d  = S_IDLE;
        end else if (change_ack_i) begin
          credit_d = credit_q - UNIT_CR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      timer_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      vend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      timer_q  <= timer_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      vend_q   <= vend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign credit_o      = credit_q;
  assign state_o       = state_q;
  assign note_accept_o = accept_q;
  assign note_reject_o = reject_q;
  assign vend_o        = vend_q;
  // Decoded purely from registers so it falls to 0 the moment reset asserts.
  assign change_req_o  = paying && credit_ge_unit;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_credit_limit: assert property (@(posedge clk) disable iff (!rst_n)
    credit_q <= MAX_CR);

  a_accept_reject_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept_q && reject_q));

endmodule
